// File: rtl/shift_unit_arbiter.sv
// Two-port round-robin arbiter in front of a shared 16-bit right shift/rotate unit.
// One registered result stage with a 1-cycle latency; a stalled result stalls both request ports.

module shift_rotate_right (
  input  logic [15:0] din,
  input  logic [3:0]  amt,
  input  logic        op,
  output logic [15:0] dout
);
  logic [15:0] s1;
  logic [15:0] s2;
  logic [15:0] s4;

  // Log-stage barrel: op=1 fills the vacated high bits with zeros, op=0 wraps the low bits in.
  always_comb begin
    s1   = amt[0] ? {(op ? 1'b0 : din[0]),   din[15:1]} : din;
    s2   = amt[1] ? {(op ? 2'b00 : s1[1:0]),  s1[15:2]} : s1;
    s4   = amt[2] ? {(op ? 4'h0 : s2[3:0]),   s2[15:4]} : s2;
    dout = amt[3] ? {(op ? 8'h00 : s4[7:0]),  s4[15:8]} : s4;
  end
endmodule

module shift_unit_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_in,
  input  logic [3:0]  req0_amt,
  input  logic        req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_in,
  input  logic [3:0]  req1_amt,
  input  logic        req1_op,
  output logic        req1_ready,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_id,
  input  logic        resp_ready,
  output logic [15:0] ops_cnt
);
  logic        prio;
  logic        grant;
  logic        can_accept;
  logic        accept;
  logic [15:0] sel_in;
  logic [3:0]  sel_amt;
  logic        sel_op;
  logic [15:0] dp_out;

  // A draining result frees the stage in the same cycle, so back-to-back accepts need no bubble.
  always_comb begin
    can_accept = ~resp_valid | resp_ready;
    grant      = (req0_valid & req1_valid) ? prio : req1_valid;
    req0_ready = can_accept & req0_valid & ~grant;
    req1_ready = can_accept & req1_valid & grant;
    accept     = req0_ready | req1_ready;
    sel_in     = grant ? req1_in  : req0_in;
    sel_amt    = grant ? req1_amt : req0_amt;
    sel_op     = grant ? req1_op  : req0_op;
  end

  shift_rotate_right u_dp (
    .din  (sel_in),
    .amt  (sel_amt),
    .op   (sel_op),
    .dout (dp_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio       <= RR_INIT;
      resp_valid <= 1'b0;
      resp_data  <= 16'h0000;
      resp_id    <= 1'b0;
      ops_cnt    <= 16'h0000;
    end else if (accept) begin
      resp_data  <= dp_out;
      resp_id    <= grant;
      resp_valid <= 1'b1;
      ops_cnt    <= ops_cnt + 16'd1;
      prio       <= ~grant;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: hand-computed vectors, inputs driven 1ns after the
// rising edge, readies sampled on the falling edge, registered outputs sampled 1ns after the edge.
module tb_shift_unit_arbiter;
  logic        clk;
  logic        rst;
  logic        req0_valid, req0_op, req0_ready;
  logic [15:0] req0_in;
  logic [3:0]  req0_amt;
  logic        req1_valid, req1_op, req1_ready;
  logic [15:0] req1_in;
  logic [3:0]  req1_amt;
  logic        resp_valid, resp_id, resp_ready;
  logic [15:0] resp_data;
  logic [15:0] ops_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_cnt;

  shift_unit_arbiter #(.RR_INIT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_in    (req0_in),
    .req0_amt   (req0_amt),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_in    (req1_in),
    .req1_amt   (req1_amt),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .ops_cnt    (ops_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Single request on one port, accepted immediately, result checked one edge later.
  task automatic issue(input bit port, input logic [15:0] din, input logic [3:0] amt,
                       input bit op, input logic [15:0] exp_data);
    if (port) begin
      req1_valid = 1'b1; req1_in = din; req1_amt = amt; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_in = din; req0_amt = amt; req0_op = op;
    end
    @(negedge clk);
    check($sformatf("ready p%0d %h", port, din), 32'(port ? req1_ready : req0_ready), 32'd1);
    check($sformatf("other_ready p%0d %h", port, din), 32'(port ? req0_ready : req1_ready), 32'd0);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    check($sformatf("data %h>>%0d op%0d", din, amt, op), 32'(resp_data), 32'(exp_data));
    check($sformatf("id %h", din), 32'(resp_id), 32'(port));
    check($sformatf("valid %h", din), 32'(resp_valid), 32'd1);
    check($sformatf("cnt %h", din), 32'(ops_cnt), 32'(exp_cnt));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req0_in = '0; req0_amt = '0; req0_op = 1'b0;
    req1_valid = 1'b0; req1_in = '0; req1_amt = '0; req1_op = 1'b0;
    resp_ready = 1'b1;
    exp_cnt    = 16'h0000;

    #12;
    check("rst valid", 32'(resp_valid), 32'd0);
    check("rst data",  32'(resp_data),  32'd0);
    check("rst id",    32'(resp_id),    32'd0);
    check("rst cnt",   32'(ops_cnt),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // T1 / T2: single-port traffic through both ops and several amounts
    issue(1'b0, 16'h8001, 4'd1,  1'b1, 16'h4000);
    issue(1'b0, 16'hF0F0, 4'd4,  1'b1, 16'h0F0F);
    issue(1'b0, 16'h1234, 4'd4,  1'b0, 16'h4123);
    issue(1'b1, 16'h8001, 4'd1,  1'b0, 16'hC000);
    issue(1'b1, 16'h0001, 4'd15, 1'b0, 16'h0002);
    issue(1'b1, 16'hFFFF, 4'd15, 1'b1, 16'h0001);
    issue(1'b1, 16'hA5A5, 4'd0,  1'b0, 16'hA5A5);

    @(posedge clk); #1;
    check("idle valid",     32'(resp_valid), 32'd0);
    check("idle data hold", 32'(resp_data),  32'hA5A5);
    check("idle id hold",   32'(resp_id),    32'd1);

    // T3: contention, priority is 0 here after a port-1 accept
    req0_valid = 1'b1; req0_in = 16'h0010; req0_amt = 4'd4; req0_op = 1'b1;
    req1_valid = 1'b1; req1_in = 16'h00F0; req1_amt = 4'd4; req1_op = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rr r0 %0d", i), 32'(req0_ready), 32'((i % 2) == 0));
      check($sformatf("rr r1 %0d", i), 32'(req1_ready), 32'((i % 2) == 1));
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 16'd1;
      check($sformatf("rr id %0d", i),   32'(resp_id),   32'(i % 2));
      check($sformatf("rr data %0d", i), 32'(resp_data), ((i % 2) == 0) ? 32'h0001 : 32'h000F);
      check($sformatf("rr cnt %0d", i),  32'(ops_cnt),   32'(exp_cnt));
    end

    // T4: backpressure holds the result and blocks both ports
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp r0 %0d", i), 32'(req0_ready), 32'd0);
      check($sformatf("bp r1 %0d", i), 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
      check($sformatf("bp valid %0d", i), 32'(resp_valid), 32'd1);
      check($sformatf("bp id %0d", i),    32'(resp_id),    32'd1);
      check($sformatf("bp data %0d", i),  32'(resp_data),  32'h000F);
      check($sformatf("bp cnt %0d", i),   32'(ops_cnt),    32'(exp_cnt));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("drain r0", 32'(req0_ready), 32'd1);
    check("drain r1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    check("drain id",   32'(resp_id),   32'd0);
    check("drain data", 32'(resp_data), 32'h0001);
    check("drain cnt",  32'(ops_cnt),   32'(exp_cnt));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    check("empty valid", 32'(resp_valid), 32'd0);
    check("empty data",  32'(resp_data),  32'h0001);

    // T5: async reset while a result is stalled and priority points at port 1
    issue(1'b0, 16'h00FF, 4'd8, 1'b0, 16'hFF00);
    resp_ready = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("arst valid", 32'(resp_valid), 32'd0);
    check("arst data",  32'(resp_data),  32'd0);
    check("arst id",    32'(resp_id),    32'd0);
    check("arst cnt",   32'(ops_cnt),    32'd0);
    req0_valid = 1'b1; req0_in = 16'h0F00; req0_amt = 4'd8; req0_op = 1'b1;
    req1_valid = 1'b1; req1_in = 16'h00F0; req1_amt = 4'd4; req1_op = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 16'h0000;
    #1;
    check("post rst r0", 32'(req0_ready), 32'd1);
    check("post rst r1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    check("post rst id",   32'(resp_id),   32'd0);
    check("post rst data", 32'(resp_data), 32'h000F);
    check("post rst cnt",  32'(ops_cnt),   32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // T6: counter wrap after 65535 accepts from a clean reset
    rst = 1'b0;
    #2;
    check("wrap pre cnt", 32'(ops_cnt), 32'd0);
    rst = 1'b1;
    req0_valid = 1'b1; req0_in = 16'h0003; req0_amt = 4'd1; req0_op = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("wrap cnt ffff", 32'(ops_cnt),    32'hFFFF);
    check("wrap data",     32'(resp_data),  32'h0001);
    check("wrap valid",    32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    check("wrap cnt 0000", 32'(ops_cnt), 32'h0000);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    check("wrap idle cnt", 32'(ops_cnt), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
